// File: rtl/ntt_core_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_core_seq_if
//  Description : Stream, control and twiddle-ROM bundle for ntt_core_seq.
//                slave  = core side, master = driver side (system or bench).
//  Signals     : start/busy/done        transform control
//                in_valid/in_ready/in_data    coefficient load stream
//                out_valid/out_ready/out_data result unload stream
//                tw_addr/tw_data        combinational twiddle ROM port
//  Revision    : 1.0  initial release
// ============================================================================
interface ntt_core_seq_if #(
    parameter int WIDTH = 30,
    parameter int LOG_N = 10
);
    logic             start;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LOG_N-1:0] tw_addr;
    logic [WIDTH-1:0] tw_data;

    modport slave (
        input  start, in_valid, in_data, out_ready, tw_data,
        output busy, done, in_ready, out_valid, out_data, tw_addr
    );

    modport master (
        output start, in_valid, in_data, out_ready, tw_data,
        input  busy, done, in_ready, out_valid, out_data, tw_addr
    );
endinterface
`default_nettype wire

// File: rtl/ntt_core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_core_seq
//  Description : Self-sequencing forward negacyclic NTT (natural order in,
//                bit-reversed order out) of N = 2^LOG_N words modulo Q.
//                One Cooley-Tukey butterfly, an N-word coefficient store and
//                an internal stage/butterfly address generator.
//  Ports       : clk          clock
//                rst_n        asynchronous active-low reset
//                bus (slave)  start/busy/done, load stream, unload stream,
//                             twiddle ROM address/data (see ntt_core_seq_if)
//                cycle_count  [31:0] busy-cycle counter, only present when
//                             NTT_CORE_SEQ_CYCLE_COUNT_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
module ntt_core_seq #(
    parameter int               WIDTH   = 30,
    parameter int               LOG_N   = 10,
    parameter logic [WIDTH-1:0] Q       = 30'd1073479681,
    parameter int               MUL_LAT = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
`ifdef NTT_CORE_SEQ_CYCLE_COUNT_EN
    output logic [31:0]       cycle_count,
`endif
    ntt_core_seq_if.slave     bus
);

    localparam int                 c_N        = 1 << LOG_N;
    localparam int                 c_SW       = $clog2(LOG_N);
    localparam int                 c_DW       = $clog2(MUL_LAT + 1);
    localparam logic [c_SW-1:0]    c_S_LAST   = c_SW'(LOG_N - 1);
    localparam logic [c_DW-1:0]    c_D_LAST   = c_DW'(MUL_LAT);
    localparam logic [LOG_N-1:0]   c_ONE      = LOG_N'(1);
    localparam logic [LOG_N-1:0]   c_PTR_LAST = LOG_N'(c_N - 1);
    localparam logic [LOG_N-1:0]   c_PTR_ZERO = '0;
    localparam logic [WIDTH:0]     c_QX       = {1'b0, Q};
    localparam logic [2*WIDTH-1:0] c_Q2       = {{WIDTH{1'b0}}, Q};

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_IDLE   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mem [c_N];
    logic [LOG_N-1:0]   r_ptr;
    logic [c_SW-1:0]    r_s;
    logic [LOG_N-2:0]   r_k;
    logic [c_DW-1:0]    r_drain;
    logic               r_busy;
    logic               r_done;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;

    logic               w_load_fire;
    logic               w_start_acc;
    logic               w_issue;
    logic               w_last_k;
    logic               w_last_s;
    logic               w_drain_end;
    logic               w_out_fire;
    logic               w_ptr_last;

    assign w_load_fire = (r_state == S_LOAD) && bus.in_valid;
    assign w_start_acc = (r_state == S_IDLE) && bus.start;
    assign w_issue     = (r_state == S_RUN);
    assign w_last_k    = &r_k;
    assign w_last_s    = (r_s == c_S_LAST);
    assign w_drain_end = (r_state == S_DRAIN) && (r_drain == c_D_LAST);
    assign w_out_fire  = (r_state == S_UNLOAD) && r_out_valid && bus.out_ready;
    assign w_ptr_last  = (r_ptr == c_PTR_LAST);

    // ------------------------------------------------------------------
    // Butterfly address generation. Bit log_t of j is always zero, so the
    // partner index j+t is formed with an OR instead of an adder.
    // ------------------------------------------------------------------
    logic [c_SW-1:0]    w_log_t;
    logic [LOG_N-1:0]   w_k_ext;
    logic [LOG_N-1:0]   w_t;
    logic [LOG_N-1:0]   w_i;
    logic [LOG_N-1:0]   w_j;
    logic [LOG_N-1:0]   w_jt;
    logic [LOG_N-1:0]   w_tw;

    always_comb begin
        w_log_t = c_S_LAST - r_s;
        w_k_ext = {1'b0, r_k};
        w_t     = c_ONE << w_log_t;
        w_i     = w_k_ext >> w_log_t;
        w_j     = ((w_i << 1) << w_log_t) | (w_k_ext & (w_t - c_ONE));
        w_jt    = w_j | w_t;
        w_tw    = (c_ONE << r_s) + w_i;
    end

    // ------------------------------------------------------------------
    // Issue: operands read from the store, product taken with the twiddle.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_u;
    logic [WIDTH-1:0]   w_v;
    logic [2*WIDTH-1:0] w_prod;

    assign w_u    = r_mem[w_j];
    assign w_v    = r_mem[w_jt];
    assign w_prod = {{WIDTH{1'b0}}, w_v} * {{WIDTH{1'b0}}, bus.tw_data};

    // ------------------------------------------------------------------
    // Multiplier pipeline. The raw product travels through MUL_LAT
    // registers and is reduced after the last one, leaving the reduction
    // and add/sub free to be retimed back across the stages.
    // ------------------------------------------------------------------
    logic [MUL_LAT-1:0] r_pl_vld;
    logic [2*WIDTH-1:0] r_pl_prod [MUL_LAT];
    logic [WIDTH-1:0]   r_pl_u    [MUL_LAT];
    logic [LOG_N-1:0]   r_pl_j    [MUL_LAT];
    logic [LOG_N-1:0]   r_pl_jt   [MUL_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pl_vld <= '0;
            for (int p = 0; p < MUL_LAT; p++) begin
                r_pl_prod[p] <= '0;
                r_pl_u[p]    <= '0;
                r_pl_j[p]    <= '0;
                r_pl_jt[p]   <= '0;
            end
        end else begin
            r_pl_vld[0]  <= w_issue;
            r_pl_prod[0] <= w_prod;
            r_pl_u[0]    <= w_u;
            r_pl_j[0]    <= w_j;
            r_pl_jt[0]   <= w_jt;
            for (int p = 1; p < MUL_LAT; p++) begin
                r_pl_vld[p]  <= r_pl_vld[p-1];
                r_pl_prod[p] <= r_pl_prod[p-1];
                r_pl_u[p]    <= r_pl_u[p-1];
                r_pl_j[p]    <= r_pl_j[p-1];
                r_pl_jt[p]   <= r_pl_jt[p-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Writeback: A = U+P mod Q, B = U-P mod Q (Q added back on underflow).
    // ------------------------------------------------------------------
    logic               w_wb_vld;
    logic [WIDTH-1:0]   w_wb_u;
    logic [WIDTH-1:0]   w_p;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    assign w_wb_vld = r_pl_vld[MUL_LAT-1];
    assign w_wb_u   = r_pl_u[MUL_LAT-1];
    assign w_p      = WIDTH'(r_pl_prod[MUL_LAT-1] % c_Q2);
    assign w_sum    = {1'b0, w_wb_u} + {1'b0, w_p};
    assign w_a      = (w_sum >= c_QX) ? WIDTH'(w_sum - c_QX) : WIDTH'(w_sum);
    assign w_b      = (w_wb_u < w_p)
                    ? WIDTH'({1'b0, w_wb_u} + c_QX - {1'b0, w_p})
                    : (w_wb_u - w_p);

    // Coefficient store: contents are undefined after reset by design.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_ptr] <= bus.in_data;
        end else if (w_wb_vld) begin
            r_mem[r_pl_j[MUL_LAT-1]]  <= w_a;
            r_mem[r_pl_jt[MUL_LAT-1]] <= w_b;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:   if (w_load_fire && w_ptr_last) w_state_nxt = S_IDLE;
            S_IDLE:   if (bus.start)                 w_state_nxt = S_RUN;
            S_RUN:    if (w_last_k)                  w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_drain_end)               w_state_nxt = w_last_s ? S_UNLOAD : S_RUN;
            S_UNLOAD: if (w_out_fire && w_ptr_last)  w_state_nxt = S_LOAD;
            default:                                 w_state_nxt = S_LOAD;
        endcase
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_s         <= '0;
            r_k         <= '0;
            r_drain     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    // Pointer wraps to zero naturally after the N-th word.
                    if (w_load_fire) r_ptr <= r_ptr + c_ONE;
                end
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_busy <= 1'b1;
                        r_s    <= '0;
                        r_k    <= '0;
                    end
                end
                S_RUN: begin
                    r_k <= r_k + 1'b1;
                end
                S_DRAIN: begin
                    if (w_drain_end) begin
                        r_drain <= '0;
                        if (w_last_s) begin
                            r_s         <= '0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_mem[c_PTR_ZERO];
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (w_out_fire) begin
                        r_ptr <= r_ptr + c_ONE;
                        if (w_ptr_last) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_data <= r_mem[r_ptr + c_ONE];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NTT_CORE_SEQ_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= '0;
        end else if (w_start_acc) begin
            r_cycle_count <= '0;
        end else if (r_busy) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.tw_addr   = (r_state == S_RUN) ? w_tw : '0;

endmodule
`default_nettype wire
